// File: rtl/riscv_mc_ctrl_pkg.sv
// rtl/riscv_mc_ctrl_pkg.sv - opcodes, state encoding and control field codes for the multi-cycle controller
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BEQ  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// rtl/riscv_mc_ctrl_if.sv - controller <-> datapath/memory control bundle
interface riscv_mc_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic       pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg
  );
endinterface

// File: rtl/riscv_mc_ctrl_wait_timer.sv
// rtl/riscv_mc_ctrl_wait_timer.sv - memory wait-state watchdog
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_en,
  output logic expired
);
  localparam int W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT - 1);

  logic [W-1:0] cnt;

  // expired marks the MAX_WAIT-th consecutive stalled cycle; a ready on that cycle never reaches here
  assign expired = wait_en && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (wait_en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multi-cycle RISC-V controller: fetch/decode/execute/memory/writeback sequencing
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_mc_ctrl_if.master  bus,
  output logic             instr_done,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t           state;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wait_en;
  logic             expired;
  logic             pc_write;
  logic             pc_write_cond;

  assign wait_en = rst_n && !bus.mem_ready && (state inside {FETCH, MEMRD, MEMWR});

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!wait_en),
    .wait_en (wait_en),
    .expired (expired)
  );

  assign trap_cause = rst_n ? cause_q : 2'b00;
  assign instr_cnt  = rst_n ? cnt_q : '0;

  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RS2;
    bus.alu_op     = ALU_ADD;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    instr_done     = 1'b0;
    trap           = 1'b0;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          pc_write      = bus.mem_ready;
        end
        DECODE: bus.alu_src_b = SRCB_IMM;
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          instr_done     = 1'b1;
        end
        MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          instr_done    = bus.mem_ready;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNC;
        end
        ALUWB: begin
          bus.reg_write = 1'b1;
          instr_done    = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_BEQ;
          bus.pc_src    = 1'b1;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
    bus.pc_en = pc_write | (pc_write_cond & bus.zero);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
      case (state)
        FETCH, MEMRD, MEMWR: begin
          // a ready on the limit cycle completes the access; only a stall there traps
          if (bus.mem_ready) begin
            state <= (state == FETCH) ? DECODE : (state == MEMRD) ? MEMWB : FETCH;
          end else if (expired) begin
            state   <= TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        DECODE: begin
          if (is_mem_op(bus.opcode))    state <= MEMADR;
          else if (bus.opcode == OP_R)   state <= EXEC;
          else if (bus.opcode == OP_BEQ) state <= BRANCH;
          else begin
            state   <= TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end
        end
        MEMADR:                state <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        EXEC:                  state <= ALUWB;
        MEMWB, ALUWB, BRANCH:  state <= FETCH;
        TRAP:                  state <= TRAP;
        default:               state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - scoreboard bench for riscv_mc_ctrl
module tb_riscv_mc_ctrl;
  typedef enum int {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                    S_EXEC, S_ALUWB, S_BRANCH, S_TRAP} bst_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [20:0] exp;
  } step_t;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;
  localparam logic [6:0] BAD_OP = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_done;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  step_t      sb[$];
  logic [3:0] m_cnt = 4'd0;
  logic [1:0] m_cause = 2'b00;

  riscv_mc_ctrl_if bus ();

  riscv_mc_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_en,
                     bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                     bus.mem_to_reg, instr_done, trap, instr_cnt, trap_cause};

  // expected control outputs of one cycle, written straight from the state table
  function automatic logic [14:0] model(input bst_t st, input logic rdy, input logic z);
    logic mr, mw, iod, irw, pce, pcs, asa, rw, m2r, dn, tr;
    logic [1:0] asb, aop;
    {mr, mw, iod, irw, pce, pcs, asa, rw, m2r, dn, tr} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      S_DECODE: asb = 2'b10;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; iod = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
      S_MEMWR:  begin mw = 1; iod = 1; dn = rdy; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_ALUWB:  begin rw = 1; dn = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pcs = 1; pce = z; dn = 1; end
      S_TRAP:   tr = 1;
      default:  ;
    endcase
    return {mr, mw, iod, irw, pce, pcs, asa, asb, aop, rw, m2r, dn, tr};
  endfunction

  task automatic push(input bst_t st, input logic rdy, input logic z, input logic [6:0] op);
    step_t s;
    logic [14:0] sig;
    sig = model(st, rdy, z);
    s.rst = 1'b0; s.rdy = rdy; s.z = z; s.op = op;
    s.exp = {sig, m_cnt, (st == S_TRAP) ? m_cause : 2'b00};
    sb.push_back(s);
    if (sig[1]) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic push_rst(input logic [6:0] op);
    step_t s;
    s.rst = 1'b1; s.rdy = 1'b0; s.z = 1'b0; s.op = op;
    s.exp = '0;
    sb.push_back(s);
    m_cnt = 4'd0;
  endtask

  task automatic test_reset;
    step_t s;
    int n = 0;
    push_rst(R_OP);
    push(S_FETCH, 1'b0, 1'b0, R_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL reset step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype;
    step_t s;
    int n = 0;
    push_rst(R_OP);
    push(S_FETCH, 1, 0, R_OP); push(S_DECODE, 1, 0, R_OP);
    push(S_EXEC, 1, 0, R_OP);  push(S_ALUWB, 1, 0, R_OP);
    push(S_FETCH, 0, 0, R_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL rtype step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_waits;
    step_t s;
    int n = 0;
    push_rst(LW_OP);
    push(S_FETCH, 0, 0, LW_OP); push(S_FETCH, 0, 0, LW_OP); push(S_FETCH, 1, 0, LW_OP);
    push(S_DECODE, 0, 0, LW_OP); push(S_MEMADR, 0, 0, LW_OP);
    for (int i = 0; i < 3; i++) push(S_MEMRD, 0, 0, LW_OP);
    push(S_MEMRD, 1, 0, LW_OP); push(S_MEMWB, 0, 0, LW_OP);
    push(S_FETCH, 0, 0, LW_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL lw_waits step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq;
    step_t s;
    int n = 0;
    push_rst(BEQ_OP);
    push(S_FETCH, 1, 1, BEQ_OP); push(S_DECODE, 1, 1, BEQ_OP); push(S_BRANCH, 1, 1, BEQ_OP);
    push(S_FETCH, 1, 0, BEQ_OP); push(S_DECODE, 1, 0, BEQ_OP); push(S_BRANCH, 1, 0, BEQ_OP);
    push(S_FETCH, 0, 1, BEQ_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL beq step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    step_t s;
    int n = 0;
    push_rst(BAD_OP);
    push(S_FETCH, 1, 0, BAD_OP); push(S_DECODE, 1, 0, BAD_OP);
    m_cause = 2'b01;
    for (int i = 0; i < 21; i++) push(S_TRAP, 1'(i), 1'(i >> 1), (i % 3 == 0) ? R_OP : BAD_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL illegal step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    step_t s;
    int n = 0;
    push_rst(SW_OP);
    push(S_FETCH, 1, 0, SW_OP); push(S_DECODE, 1, 0, SW_OP); push(S_MEMADR, 1, 0, SW_OP);
    for (int i = 0; i < 15; i++) push(S_MEMWR, 0, 0, SW_OP);
    m_cause = 2'b10;
    for (int i = 0; i < 3; i++) push(S_TRAP, 1'(i), 0, SW_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL timeout step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_limit_ready;
    step_t s;
    int n = 0;
    push_rst(SW_OP);
    push(S_FETCH, 1, 0, SW_OP); push(S_DECODE, 1, 0, SW_OP); push(S_MEMADR, 1, 0, SW_OP);
    for (int i = 0; i < 14; i++) push(S_MEMWR, 0, 0, SW_OP);
    push(S_MEMWR, 1, 0, SW_OP);
    for (int i = 0; i < 14; i++) push(S_FETCH, 0, 0, SW_OP);
    push(S_FETCH, 1, 0, SW_OP); push(S_DECODE, 1, 0, SW_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL limit_ready step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    step_t s;
    int n = 0;
    push_rst(R_OP);
    push(S_FETCH, 1, 0, R_OP); push(S_DECODE, 1, 0, R_OP);
    push(S_EXEC, 1, 0, R_OP);  push(S_ALUWB, 1, 0, R_OP);
    push(S_FETCH, 1, 0, LW_OP); push(S_DECODE, 1, 0, LW_OP); push(S_MEMADR, 1, 0, LW_OP);
    push(S_MEMRD, 1, 0, LW_OP);
    push_rst(LW_OP);
    push(S_FETCH, 0, 0, LW_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL reset_mid step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    step_t s;
    int n = 0;
    push_rst(SW_OP);
    for (int i = 0; i < 16; i++) begin
      push(S_FETCH, 1, 0, SW_OP); push(S_DECODE, 1, 0, SW_OP);
      push(S_MEMADR, 1, 0, SW_OP); push(S_MEMWR, 1, 0, SW_OP);
    end
    push(S_FETCH, 0, 0, SW_OP);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      rst_n = !s.rst; bus.mem_ready = s.rdy; bus.zero = s.z; bus.opcode = s.op;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin errors++; $display("FAIL wrap step %0d: got %h want %h", n, obs, s.exp); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = 7'd0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_illegal();
    test_timeout();
    test_limit_ready();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
